// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor. Computes DIFF = A - B one bit per
//   clock, LSB first, using a single full-subtractor cell and a registered
//   borrow. Operands are captured on an accepted start. The result appears
//   WIDTH edges later, together with a one-cycle done pulse.
//
//   Handshake: start_i is sampled only while busy_o==0, which is in IDLE or DONE.
//   The operation is accepted on the edge where start_i is high in those
//   states. busy_o is high exactly while the operation runs. done_o pulses for
//   one cycle when diff_o and the flags update. A start_i during busy_o is
//   ignored and is not queued.
//
//   Optional feature macro: SUB_OVERFLOW_EN
//     defined   -> overflow_o is the registered signed overflow of the last result
//     undefined -> overflow_o is tied to 0 and there are no extra registers
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start_i       operation request
//   a_i           minuend, captured on accepted start
//   b_i           subtrahend, captured on accepted start
//   busy_o        high while the serial operation runs
//   done_o        one-cycle pulse, result valid and updated
//   diff_o        registered result A-B mod 2^WIDTH
//   borrow_out_o  1 iff unsigned A < B
//   zero_o        1 iff diff_o == 0
//   overflow_o    signed overflow (SUB_OVERFLOW_EN only, else 0)
//   dbg_state_o   current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  // Holds the result bits produced so far. Only WIDTH-1 bits are needed
  // because the final bit is merged straight into diff on the last edge.
  logic [WIDTH-2:0] work_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, zero_q;

  // Full-subtractor cell and the next work value.
  logic             diff_bit_d;
  logic             br_d;
  logic [WIDTH-1:0] work_d;
  logic             last_bit;

  always_comb begin
    diff_bit_d = sa_q[0] ^ sb_q[0] ^ br_q;
    br_d       = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    work_d     = {diff_bit_d, work_q};
    last_bit   = (state_q == S_RUN) && (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            sa_q    <= a_i;
            sb_q    <= b_i;
            work_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sa_q   <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q   <= {1'b0, sb_q[WIDTH-1:1]};
          work_q <= work_d[WIDTH-1:1];
          br_q   <= br_d;
          if (last_bit) begin
            diff_q   <= work_d;
            borrow_q <= br_d;
            zero_q   <= (work_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  // The operand MSBs are kept aside because the shift registers lose them
  // during the run. Signed overflow happens when the operand signs differ
  // and the result sign differs from the minuend sign.
  logic accept;
  logic a_msb_q, b_msb_q, ovf_q;

  always_comb begin
    accept = start_i && (state_q != S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= a_i[WIDTH-1];
        b_msb_q <= b_i[WIDTH-1];
      end
      if (last_bit) begin
        ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ work_d[WIDTH-1]);
      end
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign diff_o       = diff_q;
  assign borrow_out_o = borrow_q;
  assign zero_o       = zero_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). The expected results
//   come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow_out, zero, overflow;
  logic [1:0]   dbg_state;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .a_i          (a_in),
    .b_i          (b_in),
    .busy_o       (busy),
    .done_o       (done),
    .diff_o       (diff),
    .borrow_out_o (borrow_out),
    .zero_o       (zero),
    .overflow_o   (overflow),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic bo,
                                output logic z, output logic ov);
    int r;
    int sr;
    r  = int'(a) - int'(b);
    d  = r[W-1:0];
    bo = (int'(a) < int'(b));
    z  = (d == '0);
    sr = int'($signed(a)) - int'($signed(b));
`ifdef SUB_OVERFLOW_EN
    ov = (sr < -(1 << (W-1))) || (sr > ((1 << (W-1)) - 1));
`else
    ov = 1'b0;
    if (sr == 0) ov = 1'b0;
`endif
  endfunction

  // ---------------- driver ----------------
  // Issues one operation from IDLE, waits for done with a cycle budget and
  // returns what was observed. lat is -1 if done never arrived.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic z,
                       output logic ov, output int lat, output bit held_ok,
                       output bit busy_ok);
    logic [W-1:0] prev;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    prev    = diff;
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    held_ok = 1'b1;
    lat     = 0;
    while (done !== 1'b1 && lat < W + 4) begin
      @(negedge clk);
      lat++;
      if (done !== 1'b1 && diff !== prev) held_ok = 1'b0;
      if (busy === 1'b1 && done === 1'b1) busy_ok = 1'b0;
    end
    if (done !== 1'b1) lat = -1;
    d  = diff;
    bo = borrow_out;
    z  = zero;
    ov = overflow;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow_out, zero, overflow, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b diff=%h bo=%b z=%b ov=%b st=%0d expected all 0",
               busy, done, diff, borrow_out, zero, overflow, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[5];
    logic [W-1:0] tb[5];
    logic [W-1:0] d, ed;
    logic bo, z, ov, ebo, ez, eov;
    int lat;
    bit held_ok, busy_ok;
    ta = '{8'h5A, 8'h00, 8'h77, 8'h80, 8'h7F};
    tb = '{8'h3C, 8'h01, 8'h77, 8'h01, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      model(ta[i], tb[i], ed, ebo, ez, eov);
      do_op(ta[i], tb[i], d, bo, z, ov, lat, held_ok, busy_ok);
      checks++;
      if (lat !== W) begin
        errors++;
        $display("FAIL directed_latency[%0d] got %0d expected %0d", i, lat, W);
      end
      checks++;
      if ({d, bo, z, ov} !== {ed, ebo, ez, eov}) begin
        errors++;
        $display("FAIL directed_result[%0d] %h-%h got diff=%h bo=%b z=%b ov=%b expected diff=%h bo=%b z=%b ov=%b",
                 i, ta[i], tb[i], d, bo, z, ov, ed, ebo, ez, eov);
      end
      checks++;
      if (!held_ok || !busy_ok) begin
        errors++;
        $display("FAIL directed_hold_busy[%0d] got held=%0d busy_ok=%0d expected 1 1", i, held_ok, busy_ok);
      end
    end
    // One cycle after done, the pulse must be gone and the result must stay.
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h80) begin
      errors++;
      $display("FAIL done_single_pulse got done=%b busy=%b diff=%h expected 0 0 80", done, busy, diff);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] d;
    logic bo, z, ov;
    int lat;
    bit held_ok, busy_ok;
    bit saw_done;
    do_op(8'h00, 8'h01, d, bo, z, ov, lat, held_ok, busy_ok);
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h5A;
    b_in  = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, zero, overflow, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run got busy=%b done=%b diff=%h bo=%b z=%b ov=%b st=%0d expected all 0",
               busy, done, diff, borrow_out, zero, overflow, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_abort got activity=1 expected 0");
    end
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] ed;
    logic ebo, ez, eov;
    int lat;
    bit busy_ok;
    model(8'hC3, 8'h4E, ed, ebo, ez, eov);
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'hC3;
    b_in  = 8'h4E;
    @(negedge clk);
    busy_ok = (busy === 1'b1);
    lat = 0;
    repeat (4) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      @(negedge clk);
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    while (done !== 1'b1 && lat < W + 4) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    checks++;
    if (lat !== W || !busy_ok) begin
      errors++;
      $display("FAIL ignore_start_timing got lat=%0d busy_ok=%0d expected %0d 1", lat, busy_ok, W);
    end
    checks++;
    if ({diff, borrow_out, zero, overflow} !== {ed, ebo, ez, eov}) begin
      errors++;
      $display("FAIL ignore_start_result got diff=%h bo=%b z=%b ov=%b expected diff=%h bo=%b z=%b ov=%b",
               diff, borrow_out, zero, overflow, ed, ebo, ez, eov);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d, ed, first;
    logic bo, z, ov, ebo, ez, eov;
    int lat;
    bit held_ok, busy_ok;
    do_op(8'h5A, 8'h3C, d, bo, z, ov, lat, held_ok, busy_ok);
    first = 8'h1E;
    // This negedge is in DONE, so the new request restarts without IDLE.
    start = 1'b1;
    a_in  = 8'h10;
    b_in  = 8'h20;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || diff !== first) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b done=%b diff=%h expected 1 0 %h", busy, done, diff, first);
    end
    held_ok = 1'b1;
    lat = 0;
    while (done !== 1'b1 && lat < W + 4) begin
      @(negedge clk);
      lat++;
      if (done !== 1'b1 && diff !== first) held_ok = 1'b0;
    end
    if (done !== 1'b1) lat = -1;
    model(8'h10, 8'h20, ed, ebo, ez, eov);
    checks++;
    if (lat !== W || !held_ok) begin
      errors++;
      $display("FAIL b2b_timing got lat=%0d held=%0d expected %0d 1", lat, held_ok, W);
    end
    checks++;
    if ({diff, borrow_out, zero, overflow} !== {ed, ebo, ez, eov}) begin
      errors++;
      $display("FAIL b2b_result got diff=%h bo=%b z=%b ov=%b expected diff=%h bo=%b z=%b ov=%b",
               diff, borrow_out, zero, overflow, ed, ebo, ez, eov);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, d, ed, exp_d;
    logic bo, z, ov, ebo, ez, eov;
    int lat;
    bit held_ok, busy_ok;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom_range(0, 255));
      b = (i % 7 == 0) ? a : W'($urandom_range(0, 255));
      model(a, b, ed, ebo, ez, eov);
      exp_q.push_back(ed);
      do_op(a, b, d, bo, z, ov, lat, held_ok, busy_ok);
      exp_d = exp_q.pop_front();
      checks++;
      if (lat !== W || d !== exp_d || {bo, z, ov} !== {ebo, ez, eov} || !held_ok || !busy_ok) begin
        errors++;
        $display("FAIL random[%0d] %h-%h got lat=%0d diff=%h bo=%b z=%b ov=%b held=%0d busy_ok=%0d expected lat=%0d diff=%h bo=%b z=%b ov=%b",
                 i, a, b, lat, d, bo, z, ov, held_ok, busy_ok, W, exp_d, ebo, ez, eov);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
